// File: rtl/ifetch_queue.sv
// Instruction fetch unit: sequential PC generation, single outstanding
// instruction-memory read, and a small FIFO of fetched words toward decode.
module ifetch_queue #(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          IADDR_WIDTH = 10,
    parameter int unsigned          DEPTH       = 2,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_en,
    output logic [IADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst_data,
    output logic [PC_WIDTH-1:0]    inst_pc,
    output logic                   inst_oor
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK       = ~PC_WIDTH'(3);
    localparam logic [PC_WIDTH-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

    // Fetch PC and the single in-flight request
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                inflight_q, inflight_d;
    logic [PC_WIDTH-1:0] fl_pc_q, fl_pc_d;
    logic                fl_oor_q, fl_oor_d;

    // Queue storage and bookkeeping
    logic [31:0]         q_data_q [DEPTH];
    logic [31:0]         q_data_d [DEPTH];
    logic [PC_WIDTH-1:0] q_pc_q   [DEPTH];
    logic [PC_WIDTH-1:0] q_pc_d   [DEPTH];
    logic                q_oor_q  [DEPTH];
    logic                q_oor_d  [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                pc_oor;
    logic                head_vld;
    logic                pop;
    logic                push;
    logic                issue;
    logic [OCC_W-1:0]    occ;

    // Handshake, issue decision and head-of-queue outputs
    always_comb begin
        pc_oor     = (pc_q >> (IADDR_WIDTH + 2)) != '0;
        head_vld   = (count_q != '0) && !rst;
        inst_valid = head_vld && !redirect_valid;
        pop        = inst_valid && inst_ready;
        // Slots already promised: stored entries plus the response on its way
        occ        = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
        issue      = !rst && !redirect_valid && (occ < OCC_W'(DEPTH));
        push       = inflight_q && !rst && !redirect_valid;
        imem_en    = issue && !pc_oor;
        imem_addr  = pc_q[IADDR_WIDTH+1:2];
        inst_data  = head_vld ? q_data_q[rd_ptr_q] : '0;
        inst_pc    = head_vld ? q_pc_q[rd_ptr_q]   : '0;
        inst_oor   = head_vld ? q_oor_q[rd_ptr_q]  : 1'b0;
    end

    // Next-state for PC, in-flight tracking and queue
    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        fl_pc_d    = fl_pc_q;
        fl_oor_d   = fl_oor_q;
        q_data_d   = q_data_q;
        q_pc_d     = q_pc_q;
        q_oor_d    = q_oor_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            pc_d       = redirect_pc & ALIGN_MASK;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = issue;
            if (issue) begin
                pc_d     = (pc_q + PC_WIDTH'(4)) & ALIGN_MASK;
                fl_pc_d  = pc_q;
                fl_oor_d = pc_oor;
            end
            if (push) begin
                q_data_d[wr_ptr_q] = fl_oor_q ? 32'h0 : imem_rdata;
                q_pc_d[wr_ptr_q]   = fl_pc_q;
                q_oor_d[wr_ptr_q]  = fl_oor_q;
                wr_ptr_d           = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC_ALIGNED;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset; validity is carried by count/inflight
    always_ff @(posedge clk) begin
        fl_pc_q  <= fl_pc_d;
        fl_oor_q <= fl_oor_d;
        q_data_q <= q_data_d;
        q_pc_q   <= q_pc_d;
        q_oor_q  <= q_oor_d;
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios with literal expectations plus a
// stream model that checks every delivered instruction and head stability.
module tb_ifetch_queue;

    localparam int unsigned PC_WIDTH    = 32;
    localparam int unsigned IADDR_WIDTH = 10;
    localparam int unsigned DEPTH       = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   redirect_valid = 1'b0;
    logic [PC_WIDTH-1:0]    redirect_pc = '0;
    logic                   imem_en;
    logic [IADDR_WIDTH-1:0] imem_addr;
    logic [31:0]            imem_rdata = '0;
    logic                   inst_valid;
    logic                   inst_ready = 1'b1;
    logic [31:0]            inst_data;
    logic [PC_WIDTH-1:0]    inst_pc;
    logic                   inst_oor;

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    ifetch_queue #(
        .PC_WIDTH   (PC_WIDTH),
        .IADDR_WIDTH(IADDR_WIDTH),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_oor      (inst_oor)
    );

    function automatic logic [31:0] mem_word(input logic [IADDR_WIDTH-1:0] w);
        return (32'(w) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic is_oor(input logic [31:0] pc);
        return (pc >> (IADDR_WIDTH + 2)) != 32'h0;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] pc);
        logic [IADDR_WIDTH-1:0] w;
        w = pc[IADDR_WIDTH+1:2];
        return is_oor(pc) ? 32'h0 : mem_word(w);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, got, exp);
        end
    endtask

    // Instruction memory: data valid one cycle after a read enable
    always @(posedge clk)
        imem_rdata <= imem_en ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    // Stream model: after reset/redirect the delivered PCs are start, start+4, ...
    logic [31:0] exp_pc = 32'h0;
    logic        hold_v = 1'b0;
    logic [31:0] hold_pc = '0;
    logic [31:0] hold_data = '0;
    logic        hold_oor = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_inst_valid", 32'(inst_valid), 32'h0);
            check("rst_inst_data",  inst_data,       32'h0);
            check("rst_inst_pc",    inst_pc,         32'h0);
            check("rst_inst_oor",   32'(inst_oor),   32'h0);
            check("rst_imem_en",    32'(imem_en),    32'h0);
            exp_pc = 32'h0;
            hold_v = 1'b0;
        end else if (redirect_valid) begin
            check("redir_inst_valid", 32'(inst_valid), 32'h0);
            check("redir_imem_en",    32'(imem_en),    32'h0);
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_valid", 32'(inst_valid), 32'h1);
                check("hold_pc",    inst_pc,         hold_pc);
                check("hold_data",  inst_data,       hold_data);
                check("hold_oor",   32'(inst_oor),   32'(hold_oor));
            end
            if (inst_valid) begin
                check("stream_pc",   inst_pc,       exp_pc);
                check("stream_data", inst_data,     exp_data(exp_pc));
                check("stream_oor",  32'(inst_oor), 32'(is_oor(exp_pc)));
                if (inst_ready) exp_pc = exp_pc + 32'h4;
            end
            hold_v    = inst_valid && !inst_ready;
            hold_pc   = inst_pc;
            hold_data = inst_data;
            hold_oor  = inst_oor;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = target;
        #2;
        check("redir_now_valid", 32'(inst_valid), 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        rst = 1'b1;
        inst_ready = 1'b1;
        repeat (3) next_cycle();

        // Reset release with decode always ready
        rst = 1'b0;
        #2;
        check("a_c0_en",    32'(imem_en),    32'h1);
        check("a_c0_addr",  32'(imem_addr),  32'h0);
        check("a_c0_valid", 32'(inst_valid), 32'h0);
        next_cycle(); #2;
        check("a_c1_addr",  32'(imem_addr),  32'h1);
        check("a_c1_valid", 32'(inst_valid), 32'h0);
        next_cycle(); #2;
        check("a_c2_addr",  32'(imem_addr),  32'h2);
        check("a_c2_valid", 32'(inst_valid), 32'h1);
        check("a_c2_pc",    inst_pc,         32'h0);
        check("a_c2_data",  inst_data,       32'h5A5A_0F0F);
        next_cycle(); #2;
        check("a_c3_pc",    inst_pc,         32'h4);
        next_cycle(); #2;
        check("a_c4_pc",    inst_pc,         32'h8);
        nv = 0;
        repeat (10) begin
            next_cycle(); #2;
            nv += int'(inst_valid);
        end
        check("a_throughput", 32'(nv), 32'd10);

        // Decode stalled from reset: queue fills with 0x0, 0x4
        next_cycle();
        rst = 1'b1;
        inst_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) next_cycle();
            #2;
            if (i >= 2) begin
                check("b_full_en",    32'(imem_en),    32'h0);
                check("b_full_valid", 32'(inst_valid), 32'h1);
                check("b_full_pc",    inst_pc,         32'h0);
            end
        end
        next_cycle();
        inst_ready = 1'b1;
        #2;
        check("b_resume_pc",   inst_pc,        32'h0);
        check("b_resume_en",   32'(imem_en),   32'h1);
        check("b_resume_addr", 32'(imem_addr), 32'h2);
        next_cycle(); #2;
        check("b_next_pc", inst_pc, 32'h4);
        next_cycle(); #2;
        check("b_next2_pc", inst_pc, 32'h8);
        repeat (3) next_cycle();

        // Redirect with a fetch in flight, unaligned target
        redirect_to(32'h103);
        #2;
        check("c_r1_en",    32'(imem_en),    32'h1);
        check("c_r1_addr",  32'(imem_addr),  32'h40);
        check("c_r1_valid", 32'(inst_valid), 32'h0);
        next_cycle(); #2;
        check("c_r2_valid", 32'(inst_valid), 32'h0);
        next_cycle(); #2;
        check("c_r3_valid", 32'(inst_valid), 32'h1);
        check("c_r3_pc",    inst_pc,         32'h100);
        repeat (2) next_cycle();

        // Back-to-back redirects: the second one wins
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        next_cycle();
        redirect_pc    = 32'h40C;
        #2;
        check("bb_valid", 32'(inst_valid), 32'h0);
        next_cycle();
        redirect_valid = 1'b0;
        #2;
        check("bb_r1_addr", 32'(imem_addr), 32'h103);
        next_cycle();
        next_cycle(); #2;
        check("bb_r3_pc", inst_pc, 32'h40C);
        repeat (2) next_cycle();

        // Last in-range word followed by first out-of-range word
        redirect_to(32'hFFC);
        #2;
        check("d_r1_en",   32'(imem_en),   32'h1);
        check("d_r1_addr", 32'(imem_addr), 32'h3FF);
        next_cycle(); #2;
        check("d_r2_en", 32'(imem_en), 32'h0);
        next_cycle(); #2;
        check("d_r3_pc",   inst_pc,       32'hFFC);
        check("d_r3_oor",  32'(inst_oor), 32'h0);
        check("d_r3_data", inst_data,     mem_word(10'h3FF));
        next_cycle(); #2;
        check("d_r4_pc",   inst_pc,       32'h1000);
        check("d_r4_oor",  32'(inst_oor), 32'h1);
        check("d_r4_data", inst_data,     32'h0);
        repeat (2) next_cycle();

        // PC wrap from the top of the address space
        redirect_to(32'hFFFF_FFFC);
        #2;
        check("e_r1_en", 32'(imem_en), 32'h0);
        next_cycle(); #2;
        check("e_r2_en",   32'(imem_en),   32'h1);
        check("e_r2_addr", 32'(imem_addr), 32'h0);
        next_cycle(); #2;
        check("e_r3_pc",   inst_pc,       32'hFFFF_FFFC);
        check("e_r3_oor",  32'(inst_oor), 32'h1);
        check("e_r3_data", inst_data,     32'h0);
        next_cycle(); #2;
        check("e_r4_pc",   inst_pc,       32'h0);
        check("e_r4_oor",  32'(inst_oor), 32'h0);
        check("e_r4_data", inst_data,     32'h5A5A_0F0F);

        // Irregular decode backpressure; the stream model checks order
        for (int i = 0; i < 80; i++) begin
            next_cycle();
            inst_ready = ($urandom_range(0, 3) != 0);
        end
        next_cycle();
        inst_ready = 1'b0;
        repeat (3) next_cycle();

        // Reset and redirect together mid-stream
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #2;
        check("f_valid", 32'(inst_valid), 32'h0);
        check("f_data",  inst_data,       32'h0);
        check("f_pc",    inst_pc,         32'h0);
        check("f_oor",   32'(inst_oor),   32'h0);
        check("f_en",    32'(imem_en),    32'h0);
        next_cycle();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        #2;
        check("f_c0_en",    32'(imem_en),    32'h1);
        check("f_c0_addr",  32'(imem_addr),  32'h0);
        check("f_c0_valid", 32'(inst_valid), 32'h0);
        next_cycle();
        next_cycle(); #2;
        check("f_c2_valid", 32'(inst_valid), 32'h1);
        check("f_c2_pc",    inst_pc,         32'h0);
        repeat (4) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
